mem_port_arbiter: RTL and testbench

- Shares the single-port 32x8 synchronous memory between the instruction-fetch unit (read-only) and the stack/data unit (read/write) of the multicycle stack CPU.
- Takes req/gnt/rvalid transactions from both requesters and drives the memory's address, writeData, memRead and memWrite pins.
- Uses fair round-robin arbitration. The FSM accounts for the memory's one-cycle registered read latency.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 29 ++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
// Contents:
//   ADDR_W, DATA_W : default memory address and word widths (32 x 8)
//   state_t        : arbiter FSM states
//   owner_t        : which requester owns the command in flight
package mem_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between the fetch and data requesters.
// Purely combinational; the "last winner" history lives in the parent.
// Ports:
//   f_req, d_req : request lines
//   last         : owner granted most recently
//   valid        : at least one request present
//   winner       : chosen requester (meaningful only when valid)
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   f_req,
  input  logic   d_req,
  input  owner_t last,
  output logic   valid,
  output owner_t winner
);

  always_comb begin
    valid  = f_req | d_req;
    winner = OWN_FETCH;
    if (f_req && d_req) begin
      // On a tie the side that did not win last time goes next.
      winner = (last == OWN_DATA) ? OWN_FETCH : OWN_DATA;
    end else if (d_req) begin
      winner = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port synchronous memory (registered read, one cycle
// latency) between a read-only fetch port and a read/write data port.
// Each command occupies a CMD cycle; reads are followed by a RESP cycle
// in which the owner's rvalid is high and a new winner may be chosen.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   f_req/f_addr -> f_gnt/f_rvalid/f_rdata           : fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata : data requester
//   mem_addr/mem_wdata/mem_read/mem_write -> memory, mem_out <- memory
module mem_port_arbiter #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out
);
  import mem_arb_pkg::*;

  state_t state_reg, state_next;
  owner_t owner_reg, owner_next;
  owner_t last_reg, last_next;
  logic   f_gnt_reg, f_gnt_next, d_gnt_reg, d_gnt_next;
  logic   f_rvalid_reg, f_rvalid_next, d_rvalid_reg, d_rvalid_next;
  logic   mem_read_reg, mem_read_next, mem_write_reg, mem_write_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;

  logic   arb_valid;
  owner_t arb_winner;

  rr_arb2 u_rr_arb2 (
    .f_req  (f_req),
    .d_req  (d_req),
    .last   (last_reg),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    last_next      = last_reg;
    f_gnt_next     = 1'b0;
    d_gnt_next     = 1'b0;
    f_rvalid_next  = 1'b0;
    d_rvalid_next  = 1'b0;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;

    case (state_reg)
      // RESP arbitrates exactly like IDLE so reads can be issued
      // back to back at one command every two cycles.
      IDLE, RESP: begin
        if (arb_valid) begin
          state_next = CMD;
          owner_next = arb_winner;
          last_next  = arb_winner;
          if (arb_winner == OWN_FETCH) begin
            mem_addr_next = f_addr;
            mem_read_next = 1'b1;
            f_gnt_next    = 1'b1;
          end else begin
            mem_addr_next  = d_addr;
            mem_wdata_next = d_wdata;
            mem_read_next  = ~d_we;
            mem_write_next = d_we;
            d_gnt_next     = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      // Requests are not sampled here: the requester drops or replaces
      // its request after seeing gnt, so nothing is granted twice.
      CMD: begin
        if (mem_read_reg) begin
          state_next    = RESP;
          f_rvalid_next = (owner_reg == OWN_FETCH);
          d_rvalid_next = (owner_reg == OWN_DATA);
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_FETCH;
      last_reg      <= OWN_DATA;
      f_gnt_reg     <= 1'b0;
      d_gnt_reg     <= 1'b0;
      f_rvalid_reg  <= 1'b0;
      d_rvalid_reg  <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_reg      <= last_next;
      f_gnt_reg     <= f_gnt_next;
      d_gnt_reg     <= d_gnt_next;
      f_rvalid_reg  <= f_rvalid_next;
      d_rvalid_reg  <= d_rvalid_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  assign f_gnt     = f_gnt_reg;
  assign d_gnt     = d_gnt_reg;
  assign f_rvalid  = f_rvalid_reg;
  assign d_rvalid  = d_rvalid_reg;
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  // Read data passes straight from the memory output; it is forced to
  // zero outside its rvalid cycle so the ports read 0 out of reset.
  assign f_rdata = f_rvalid_reg ? mem_out : '0;
  assign d_rdata = d_rvalid_reg ? mem_out : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       f_req = 1'b0;
  logic [4:0] f_addr = '0;
  logic       f_gnt, f_rvalid;
  logic [7:0] f_rdata;
  logic       d_req = 1'b0;
  logic       d_we = 1'b0;
  logic [4:0] d_addr = '0;
  logic [7:0] d_wdata = '0;
  logic       d_gnt, d_rvalid;
  logic [7:0] d_rdata;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_read, mem_write;
  logic [7:0] mem_out = '0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // Environment memory: 32x8, registered read, ignores rst.
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (mem_write === 1'b1) mem[mem_addr] <= mem_wdata;
    if (mem_read === 1'b1) mem_out <= mem[mem_addr];
  end

  function automatic logic [7:0] init_val(input int i);
    case (i)
      0:  return 8'h9D;
      2:  return 8'h00;
      27: return 8'h66;
      28: return 8'hAA;
      29: return 8'h08;
      30: return 8'h10;
      default: return 8'((i * 7) + 3);
    endcase
  endfunction

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction rules) ----------------
  // Rules: a grant can happen at any edge that does not directly follow a
  // grant edge; ties go to whoever did not win last; a read returns data
  // one edge after its grant edge unless that edge is a reset edge; every
  // command presented to memory executes, reset or not.
  logic [7:0] ref_mem [32];
  bit         m_last_data;
  bit         g_valid, g_data, g_we;
  logic [4:0] g_addr;
  logic [7:0] g_wdata;
  bit         e_fgnt, e_dgnt, e_rd, e_wr, e_frv, e_drv, e_after_rst;
  logic [4:0] e_addr;
  logic [7:0] e_wdata, e_rdata;

  task automatic tick();
    bit grant_now = 1'b0;
    bit win_data = 1'b0;
    e_frv = 1'b0;
    e_drv = 1'b0;
    if (g_valid) begin
      if (g_we) ref_mem[g_addr] = g_wdata;
      else if (!rst) begin
        e_rdata = ref_mem[g_addr];
        if (g_data) e_drv = 1'b1; else e_frv = 1'b1;
      end
    end
    if (rst) begin
      m_last_data = 1'b1;
      e_addr = '0;
      e_wdata = '0;
    end else if (!g_valid && (f_req || d_req)) begin
      grant_now = 1'b1;
      win_data = (f_req && d_req) ? !m_last_data : d_req;
      m_last_data = win_data;
    end
    g_valid = grant_now;
    g_data  = win_data;
    g_we    = win_data && d_we;
    g_addr  = win_data ? d_addr : f_addr;
    g_wdata = d_wdata;
    e_fgnt = grant_now && !win_data;
    e_dgnt = grant_now && win_data;
    e_rd   = grant_now && !g_we;
    e_wr   = grant_now && g_we;
    if (grant_now) begin
      e_addr = g_addr;
      if (g_we) e_wdata = g_wdata;
      $display("cyc %0d grant %s %s addr %0d wdata %02h", cyc + 1,
               win_data ? "D" : "F", g_we ? "WR" : "RD", g_addr, g_wdata);
    end
    e_after_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
    chk("f_gnt", f_gnt, e_fgnt);
    chk("d_gnt", d_gnt, e_dgnt);
    chk("mem_read", mem_read, e_rd);
    chk("mem_write", mem_write, e_wr);
    chk("f_rvalid", f_rvalid, e_frv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("strobe_excl", mem_read & mem_write, 1'b0);
    if (e_frv) chk("f_rdata", f_rdata, e_rdata);
    if (e_drv) chk("d_rdata", d_rdata, e_rdata);
    if (e_rd || e_wr || e_after_rst) chk("mem_addr", mem_addr, e_addr);
    if (e_wr || e_after_rst) chk("mem_wdata", mem_wdata, e_wdata);
    if (e_after_rst) begin
      chk("rst f_rdata", f_rdata, 8'h00);
      chk("rst d_rdata", d_rdata, 8'h00);
    end
  endtask

  // ---------------- queued requesters ----------------
  typedef struct {
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } dop_t;
  logic [4:0] fq[$];
  dop_t       dq[$];
  int         gnt_cyc[$];
  bit         gnt_order[$];
  int         drv_cyc[$];
  logic [7:0] drv_data[$];

  task automatic observe();
    if (f_gnt) begin gnt_cyc.push_back(cyc); gnt_order.push_back(1'b0); end
    if (d_gnt) begin gnt_cyc.push_back(cyc); gnt_order.push_back(1'b1); end
    if (d_rvalid) begin drv_cyc.push_back(cyc); drv_data.push_back(d_rdata); end
  endtask

  task automatic clear_obs();
    gnt_cyc.delete(); gnt_order.delete(); drv_cyc.delete(); drv_data.delete();
  endtask

  task automatic load_d();
    dop_t o;
    o = dq.pop_front();
    d_req = 1'b1; d_we = o.we; d_addr = o.addr; d_wdata = o.wdata;
  endtask

  task automatic run_queues(input int budget);
    int n = 0;
    if (fq.size() > 0) begin f_req = 1'b1; f_addr = fq.pop_front(); end
    if (dq.size() > 0) load_d();
    while ((f_req || d_req) && n < budget) begin
      tick();
      n++;
      observe();
      if (f_gnt) begin
        if (fq.size() > 0) f_addr = fq.pop_front(); else f_req = 1'b0;
      end
      if (d_gnt) begin
        if (dq.size() > 0) load_d(); else d_req = 1'b0;
      end
    end
    chk("queue budget", {30'd0, f_req, d_req}, 32'd0);
    f_req = 1'b0; d_req = 1'b0;
    fq.delete(); dq.delete();
    repeat (3) begin tick(); observe(); end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    g_valid = 1'b0; m_last_data = 1'b1; e_addr = '0; e_wdata = '0; e_rdata = '0;

    // Reset state
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();

    // 1: fetch read of address 0
    f_req = 1'b1; f_addr = 5'd0;
    tick();
    chk("t1 f_gnt", f_gnt, 1'b1);
    chk("t1 mem_read", mem_read, 1'b1);
    chk("t1 mem_addr", mem_addr, 5'd0);
    f_req = 1'b0;
    tick();
    chk("t1 f_rvalid", f_rvalid, 1'b1);
    chk("t1 f_rdata", f_rdata, 8'h9D);
    tick();

    // 2: data write 31 <- BB, then read it back
    d_req = 1'b1; d_we = 1'b1; d_addr = 5'd31; d_wdata = 8'hBB;
    tick();
    chk("t2 d_gnt wr", d_gnt, 1'b1);
    chk("t2 mem_write", mem_write, 1'b1);
    chk("t2 mem_wdata", mem_wdata, 8'hBB);
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_wdata = 8'h00;
    tick();
    chk("t2 d_gnt rd", d_gnt, 1'b1);
    d_req = 1'b0;
    tick();
    chk("t2 d_rvalid", d_rvalid, 1'b1);
    chk("t2 d_rdata", d_rdata, 8'hBB);
    tick();

    // 3: both requesters, four reads each, from reset
    do_reset();
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      fq.push_back(5'(i + 4));
      dq.push_back('{we: 1'b0, addr: 5'(i + 12), wdata: 8'h00});
    end
    run_queues(40);
    chk("t3 grant count", gnt_order.size(), 8);
    for (int i = 0; i < 8 && i < gnt_order.size(); i++)
      chk("t3 grant order", gnt_order[i], i % 2);
    for (int i = 0; i + 1 < gnt_cyc.size(); i++)
      chk("t3 grant spacing", gnt_cyc[i + 1] - gnt_cyc[i], 2);

    // 4: fetch read then data write issued in the fetch's RESP cycle
    clear_obs();
    fq.push_back(5'd2);
    dq.push_back('{we: 1'b1, addr: 5'd30, wdata: 8'h10});
    run_queues(20);
    chk("t4 grant count", gnt_cyc.size(), 2);
    if (gnt_cyc.size() == 2) chk("t4 write in RESP", gnt_cyc[1] - gnt_cyc[0], 2);

    // 5: reset during the CMD cycle of a fetch read
    f_req = 1'b1; f_addr = 5'd7;
    tick();
    chk("t5 f_gnt", f_gnt, 1'b1);
    f_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t5 no f_rvalid", f_rvalid, 1'b0);
    f_req = 1'b1; f_addr = 5'd9; d_req = 1'b1; d_we = 1'b0; d_addr = 5'd10;
    tick();
    chk("t5 tie to fetch", f_gnt, 1'b1);
    chk("t5 tie not data", d_gnt, 1'b0);
    f_req = 1'b0;
    tick();
    tick();
    chk("t5 data next", d_gnt, 1'b1);
    d_req = 1'b0;
    repeat (3) tick();

    // 6: continuous data reads of 27..30
    clear_obs();
    for (int i = 27; i <= 30; i++) dq.push_back('{we: 1'b0, addr: 5'(i), wdata: 8'h00});
    run_queues(30);
    chk("t6 rvalid count", drv_data.size(), 4);
    if (drv_data.size() == 4) begin
      chk("t6 rdata27", drv_data[0], 8'h66);
      chk("t6 rdata28", drv_data[1], 8'hAA);
      chk("t6 rdata29", drv_data[2], 8'h08);
      chk("t6 rdata30", drv_data[3], 8'h10);
      for (int i = 0; i < 3; i++) chk("t6 rvalid spacing", drv_cyc[i + 1] - drv_cyc[i], 2);
    end

    // Random traffic with occasional reset, checked by the model every cycle
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      tick();
      if (!f_req || f_gnt) begin
        f_req = ($urandom_range(0, 1) == 1);
        f_addr = 5'($urandom_range(0, 31));
      end
      if (!d_req || d_gnt) begin
        d_req = ($urandom_range(0, 1) == 1);
        d_we = ($urandom_range(0, 1) == 1);
        d_addr = 5'($urandom_range(0, 31));
        d_wdata = 8'($urandom_range(0, 255));
      end
    end
    rst = 1'b0; f_req = 1'b0; d_req = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
